// File: rtl/team_06_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : team_06_wb_pkg
// Description : Shared types and default constants for the Team 06 Wishbone
//               manager: request record, FSM state encoding, default sizes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package team_06_wb_pkg;

   localparam int WB_ADDR_W_DEF  = 32;
   localparam int WB_DATA_W_DEF  = 32;
   localparam int WB_QDEPTH_DEF  = 2;
   localparam int WB_TIMEOUT_DEF = 255;

   // Request record at the default bus widths; the manager builds an
   // equivalent record at its own parameterised widths.
   typedef struct packed {
      logic                          we;
      logic [WB_ADDR_W_DEF-1:0]      addr;
      logic [WB_DATA_W_DEF-1:0]      data;
      logic [WB_DATA_W_DEF/8-1:0]    sel;
   } wb_req_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } wb_mgr_state_t;

endpackage
`default_nettype wire

// File: rtl/team_06_wb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : team_06_wb_req_fifo
// Description : Synchronous request FIFO with first-word-fall-through read
//               port. DEPTH must be a power of two and at least 2.
// Ports       : clk, nrst        - clock, asynchronous active-low reset
//               push_i, push_data_i - write strobe/data (ignored when full)
//               pop_i            - remove head entry (ignored when empty)
//               pop_data_o       - current head entry
//               full_o, empty_o  - occupancy flags from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module team_06_wb_req_fifo
   import team_06_wb_pkg::*;
#(
   parameter int  DEPTH = WB_QDEPTH_DEF,
   parameter type T     = wb_req_t
) (
   input  logic clk,
   input  logic nrst,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   T                 mem_q [DEPTH];
   T                 mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign pop_data_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data_i;
         // Pointers wrap naturally because DEPTH is a power of two.
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/team_06_wb_manager.sv
`default_nettype none
// ============================================================================
// Module      : team_06_wb_manager
// Description : Wishbone B4 classic-cycle initiator. Queues single-word
//               read/write requests and runs one bus cycle at a time, with a
//               watchdog that aborts cycles that are never acknowledged.
// Ports       : clk, nrst                 - clock, async active-low reset
//               req_write_i/req_read_i    - request strobes (write wins)
//               req_addr_i/wdata_i/sel_i  - request payload
//               req_ready_o               - queue not full
//               rd_data_o/rd_valid_o      - last read data and update pulse
//               busy_o                    - work queued or cycle in progress
//               timeout_o                 - pulse when a cycle is aborted
//               ADR_O..CYC_O, DAT_I, ACK_I - Wishbone initiator interface
// Revision    : 1.0 - initial release
// ============================================================================
module team_06_wb_manager
   import team_06_wb_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_W_DEF,
   parameter int DATA_W  = WB_DATA_W_DEF,
   parameter int QDEPTH  = WB_QDEPTH_DEF,
   parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                req_write_i,
   input  logic                req_read_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_sel_i,
   output logic                req_ready_o,
   output logic [DATA_W-1:0]   rd_data_o,
   output logic                rd_valid_o,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [ADDR_W-1:0]   ADR_O,
   output logic [DATA_W-1:0]   DAT_O,
   output logic [DATA_W/8-1:0] SEL_O,
   output logic                WE_O,
   output logic                STB_O,
   output logic                CYC_O,
   input  logic [DATA_W-1:0]   DAT_I,
   input  logic                ACK_I
);

   localparam int SEL_W = DATA_W / 8;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [SEL_W-1:0]  sel;
   } req_t;

   req_t          push_req;
   req_t          head_req;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;

   wb_mgr_state_t state_q,    state_d;
   logic [WD_W-1:0] wdog_q,   wdog_d;
   logic [ADDR_W-1:0] adr_q,  adr_d;
   logic [DATA_W-1:0] dat_q,  dat_d;
   logic [SEL_W-1:0]  sel_q,  sel_d;
   logic          we_q,       we_d;
   logic          cyc_q,      cyc_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          timeout_q,  timeout_d;

   // A simultaneous read+write strobe is recorded as a write.
   assign push     = (req_write_i | req_read_i) & req_ready_o;
   assign push_req = '{we: req_write_i, addr: req_addr_i,
                       data: req_wdata_i, sel: req_sel_i};

   team_06_wb_req_fifo #(
      .DEPTH (QDEPTH),
      .T     (req_t)
   ) u_req_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .push_i      (push),
      .push_data_i (push_req),
      .pop_i       (pop),
      .pop_data_o  (head_req),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      wdog_d     = wdog_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      sel_d      = sel_q;
      we_d       = we_q;
      cyc_d      = cyc_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      timeout_d  = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            // ACK_I is not looked at here, so a stray ACK outside a cycle
            // has no effect.
            if (!fifo_empty) begin
               pop     = 1'b1;
               adr_d   = head_req.addr;
               dat_d   = head_req.data;
               sel_d   = head_req.sel;
               we_d    = head_req.we;
               cyc_d   = 1'b1;
               wdog_d  = '0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // ACK takes priority over an expiring watchdog.
            if (ACK_I) begin
               cyc_d   = 1'b0;
               state_d = IDLE;
               if (!we_q) begin
                  rd_data_d  = DAT_I;
                  rd_valid_d = 1'b1;
               end
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               cyc_d     = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         wdog_q     <= '0;
         adr_q      <= '0;
         dat_q      <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wdog_q     <= wdog_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         cyc_q      <= cyc_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         timeout_q  <= timeout_d;
      end
   end

   assign req_ready_o = ~fifo_full;
   assign busy_o      = ~fifo_empty | (state_q == ACTIVE);
   assign rd_data_o   = rd_data_q;
   assign rd_valid_o  = rd_valid_q;
   assign timeout_o   = timeout_q;
   assign ADR_O       = adr_q;
   assign DAT_O       = dat_q;
   assign SEL_O       = sel_q;
   assign WE_O        = we_q;
   // Classic single-word cycles: strobe and cycle always move together.
   assign CYC_O       = cyc_q;
   assign STB_O       = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_team_06_wb_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_team_06_wb_manager
// Description : Self-checking bench for team_06_wb_manager with a scoreboard
//               of expected bus cycles and a programmable responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_team_06_wb_manager;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        req_write_i = 1'b0;
   logic        req_read_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [3:0]  req_sel_i = '0;
   logic        req_ready_o;
   logic [31:0] rd_data_o;
   logic        rd_valid_o;
   logic        busy_o;
   logic        timeout_o;
   logic [31:0] ADR_O;
   logic [31:0] DAT_O;
   logic [3:0]  SEL_O;
   logic        WE_O;
   logic        STB_O;
   logic        CYC_O;
   logic [31:0] DAT_I = '0;
   logic        ACK_I = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      int          len;
      int          gap;
      bit          stable;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   obs_t cur;
   bit   in_cyc  = 1'b0;
   int   gap_cnt = 100;
   int   rdv_cnt = 0;
   int   to_cnt  = 0;

   // Responder controls
   bit          resp_en   = 1'b0;
   int          resp_wait = 0;
   int          wcnt      = 0;

   team_06_wb_manager #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .QDEPTH  (2),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .req_write_i (req_write_i),
      .req_read_i  (req_read_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_sel_i   (req_sel_i),
      .req_ready_o (req_ready_o),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .ADR_O       (ADR_O),
      .DAT_O       (DAT_O),
      .SEL_O       (SEL_O),
      .WE_O        (WE_O),
      .STB_O       (STB_O),
      .CYC_O       (CYC_O),
      .DAT_I       (DAT_I),
      .ACK_I       (ACK_I)
   );

   always #5 clk = ~clk;

   // Responder: ACK after resp_wait wait states while enabled.
   always @(negedge clk) begin
      if (STB_O) begin
         ACK_I = resp_en && (wcnt >= resp_wait);
         wcnt  = wcnt + 1;
      end else begin
         ACK_I = 1'b0;
         wcnt  = 0;
      end
   end

   // Bus monitor: records each completed cycle with its length and the
   // number of idle CYC samples preceding it.
   always @(negedge clk) begin
      if (CYC_O) begin
         if (!in_cyc) begin
            cur.we = WE_O; cur.addr = ADR_O; cur.data = DAT_O; cur.sel = SEL_O;
            cur.len = 0; cur.gap = gap_cnt; cur.stable = 1'b1;
            in_cyc = 1'b1;
         end else if (cur.we !== WE_O || cur.addr !== ADR_O ||
                      cur.data !== DAT_O || cur.sel !== SEL_O) begin
            cur.stable = 1'b0;
         end
         if (STB_O !== 1'b1) cur.stable = 1'b0;
         cur.len = cur.len + 1;
      end else begin
         if (in_cyc) begin
            obs_q.push_back(cur);
            in_cyc  = 1'b0;
            gap_cnt = 0;
         end
         gap_cnt = gap_cnt + 1;
      end
      if (rd_valid_o) rdv_cnt = rdv_cnt + 1;
      if (timeout_o)  to_cnt  = to_cnt + 1;
   end

   task automatic drive_req(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input bit expect_acc);
      exp_t e;
      req_write_i = wr; req_read_i = rd;
      req_addr_i = a; req_wdata_i = d; req_sel_i = s;
      if (expect_acc) begin
         e.we = wr; e.addr = a; e.data = d; e.sel = s;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_write_i = 1'b0; req_read_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy_o && !CYC_O) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({CYC_O, STB_O, WE_O, rd_valid_o, timeout_o, busy_o, req_ready_o} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_ctrl: got cyc,stb,we,rdv,to,busy,rdy=%b required 0000001",
                  {CYC_O, STB_O, WE_O, rd_valid_o, timeout_o, busy_o, req_ready_o});
      end
      checks++;
      if ({ADR_O, DAT_O, SEL_O, rd_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_data: adr=%h dat=%h sel=%h rd=%h required all 0",
                  ADR_O, DAT_O, SEL_O, rd_data_o);
      end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      bit ok; obs_t o; exp_t e; int rdv0;
      rdv0 = rdv_cnt; resp_en = 1'b1; resp_wait = 0;
      drive_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wr_idle: busy never cleared, required idle"); end
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL wr_count: obs=%0d exp=%0d required 1", obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if ({o.we, o.addr, o.data, o.sel} !== {e.we, e.addr, e.data, e.sel}) begin
            errors++;
            $display("FAIL wr_fields: got we=%b adr=%h dat=%h sel=%h required we=%b adr=%h dat=%h sel=%h",
                     o.we, o.addr, o.data, o.sel, e.we, e.addr, e.data, e.sel);
         end
         checks++;
         if (o.len != 1 || !o.stable) begin
            errors++;
            $display("FAIL wr_len: got len=%0d stable=%0d required len=1 stable=1", o.len, o.stable);
         end
      end
      checks++;
      if (rdv_cnt != rdv0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wr_rdv_busy: rdv pulses=%0d busy=%b required 0 and 0", rdv_cnt - rdv0, busy_o);
      end
   endtask

   task automatic test_read_wait();
      bit ok; obs_t o; exp_t e; int rdv0;
      rdv0 = rdv_cnt; resp_en = 1'b1; resp_wait = 3; DAT_I = 32'h12345678;
      drive_req(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL rd_count: ok=%0d obs=%0d exp=%0d required 1,1,1", ok, obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if ({o.we, o.addr, o.sel} !== {e.we, e.addr, e.sel} || o.len != 4) begin
            errors++;
            $display("FAIL rd_cycle: got we=%b adr=%h sel=%h len=%0d required we=%b adr=%h sel=%h len=4",
                     o.we, o.addr, o.sel, o.len, e.we, e.addr, e.sel);
         end
      end
      checks++;
      if (rd_data_o !== 32'h12345678 || rdv_cnt - rdv0 != 1) begin
         errors++;
         $display("FAIL rd_data: got %h pulses=%0d required 12345678 pulses=1", rd_data_o, rdv_cnt - rdv0);
      end
      DAT_I = 32'h0;
   endtask

   task automatic test_queue_full();
      bit ok; obs_t o; exp_t e;
      resp_en = 1'b0; resp_wait = 0;
      drive_req(1'b1, 1'b0, 32'h100, 32'h11111111, 4'hF, 1'b1);
      drive_req(1'b1, 1'b0, 32'h104, 32'h22222222, 4'h3, 1'b1);
      drive_req(1'b1, 1'b0, 32'h108, 32'h33333333, 4'hC, 1'b1);
      checks++;
      if (req_ready_o !== 1'b0 || CYC_O !== 1'b1) begin
         errors++;
         $display("FAIL qf_full: ready=%b cyc=%b required ready=0 cyc=1", req_ready_o, CYC_O);
      end
      drive_req(1'b1, 1'b0, 32'h10C, 32'h44444444, 4'hF, 1'b0);
      resp_en = 1'b1;
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 3 || exp_q.size() != 3) begin
         errors++;
         $display("FAIL qf_count: ok=%0d obs=%0d exp=%0d required 1,3,3", ok, obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if ({o.we, o.addr, o.data, o.sel} !== {e.we, e.addr, e.data, e.sel} || !o.stable ||
                (i > 0 && o.gap < 1)) begin
               errors++;
               $display("FAIL qf_cycle%0d: got adr=%h dat=%h sel=%h gap=%0d stable=%0d required adr=%h dat=%h sel=%h gap>=1 stable=1",
                        i, o.addr, o.data, o.sel, o.gap, o.stable, e.addr, e.data, e.sel);
            end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok; obs_t o; int rdv0, to0;
      rdv0 = rdv_cnt; to0 = to_cnt; resp_en = 1'b0;
      drive_req(1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 1) begin
         errors++;
         $display("FAIL to_count: ok=%0d obs=%0d required 1,1", ok, obs_q.size());
         obs_q.delete();
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o.len != 8 || o.addr !== 32'h40 || o.we !== 1'b0) begin
            errors++;
            $display("FAIL to_len: got len=%0d adr=%h we=%b required len=8 adr=00000040 we=0", o.len, o.addr, o.we);
         end
      end
      exp_q.delete();
      checks++;
      if (to_cnt - to0 != 1 || rdv_cnt != rdv0 || rd_data_o !== 32'h12345678) begin
         errors++;
         $display("FAIL to_pulse: to=%0d rdv=%0d rd=%h required 1,0,12345678", to_cnt - to0, rdv_cnt - rdv0, rd_data_o);
      end
      resp_en = 1'b1;
      drive_req(1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 4'h5, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL to_next: ok=%0d obs=%0d exp=%0d required 1,1,1", ok, obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end else begin
         o = obs_q.pop_front(); void'(exp_q.pop_front());
         checks++;
         if (o.len != 1 || o.addr !== 32'h44 || o.data !== 32'hCAFEF00D || to_cnt - to0 != 1) begin
            errors++;
            $display("FAIL to_next_cycle: len=%0d adr=%h dat=%h to=%0d required 1,00000044,cafef00d,1",
                     o.len, o.addr, o.data, to_cnt - to0);
         end
      end
   endtask

   task automatic test_collision();
      bit ok; obs_t o; exp_t e;
      resp_en = 1'b1; resp_wait = 1;
      drive_req(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 1'b1);
      wait_idle(ok);
      checks++;
      if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL col_count: ok=%0d obs=%0d exp=%0d required 1,1,1", ok, obs_q.size(), exp_q.size());
         obs_q.delete(); exp_q.delete();
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if ({o.we, o.addr, o.data} !== {e.we, e.addr, e.data}) begin
            errors++;
            $display("FAIL col_fields: got we=%b adr=%h dat=%h required we=1 adr=%h dat=%h",
                     o.we, o.addr, o.data, e.addr, e.data);
         end
      end
   endtask

   task automatic test_reset_mid();
      resp_en = 1'b0;
      drive_req(1'b1, 1'b0, 32'h50, 32'h55555555, 4'hF, 1'b1);
      drive_req(1'b1, 1'b0, 32'h54, 32'h66666666, 4'hF, 1'b1);
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (CYC_O !== 1'b0 || STB_O !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: cyc=%b stb=%b busy=%b required 0,0,0", CYC_O, STB_O, busy_o);
      end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      #1;
      obs_q.delete(); exp_q.delete();
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (obs_q.size() != 0 || in_cyc || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_after: cycles=%0d in_cyc=%0d busy=%b ready=%b required 0,0,0,1",
                  obs_q.size(), in_cyc, busy_o, req_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_queue_full();
      test_timeout();
      test_collision();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire

// File: doc/team_06_wb_manager.md
Name: team_06_wb_manager

Overview:
Wishbone B4 classic-cycle initiator for the Team 06 audio datapath. It converts single-word read/write requests from the audio core into Wishbone bus cycles toward the SRAM Wishbone wrapper (the responder). Requests are buffered in a small queue, and only one bus cycle is outstanding at a time. A watchdog aborts any cycle the responder never acknowledges.

Parameters:
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width
QDEPTH, 2, request queue depth; must be a power of two and at least 2
TIMEOUT, 255, number of STB cycles without ACK before the cycle is aborted

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
req_write_i  in  1  write request strobe, sampled only while req_ready_o=1
req_read_i  in  1  read request strobe, sampled only while req_ready_o=1
req_addr_i  in  ADDR_W  request address
req_wdata_i  in  DATA_W  write data
req_sel_i  in  DATA_W/8  byte enables
req_ready_o  out  1  queue not full
rd_data_o  out  DATA_W  last read data
rd_valid_o  out  1  one-cycle pulse when rd_data_o is updated
busy_o  out  1  queue non-empty or a bus cycle is in progress
timeout_o  out  1  one-cycle pulse when a cycle is aborted
ADR_O  out  ADDR_W  Wishbone address
DAT_O  out  DATA_W  Wishbone write data
SEL_O  out  DATA_W/8  Wishbone byte selects
WE_O  out  1  Wishbone write enable
STB_O  out  1  Wishbone strobe
CYC_O  out  1  Wishbone cycle
DAT_I  in  DATA_W  Wishbone read data
ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Clock and reset: single clock clk. nrst is asynchronous, active-low. Every register clears immediately on assertion.
- Reset values: all outputs are 0, except req_ready_o=1. Queue is empty, FSM is in IDLE, watchdog counter is 0.
- Request acceptance:
  - A request is accepted on a rising edge where (req_write_i|req_read_i) & req_ready_o.
  - If req_write_i and req_read_i are both high, the write wins and the read is dropped.
  - Strobes asserted while req_ready_o=0 are ignored; the request is lost.
  - The queue holds {we, addr, data, sel}. req_ready_o = !full, registered from the queue count.
- FSM states: IDLE, ACTIVE.
  - IDLE with queue non-empty: pop the head. On the same edge, register ADR_O, DAT_O, SEL_O and WE_O, set CYC_O=STB_O=1, clear the watchdog, and go to ACTIVE.
  - ACTIVE with ACK_I=1: drop CYC_O and STB_O to 0 on that edge and go to IDLE. For a read, rd_data_o<=DAT_I and rd_valid_o=1 for exactly the following cycle. For a write, there is no pulse.
  - ACTIVE with ACK_I=0: watchdog increments. When watchdog==TIMEOUT-1 and ACK_I=0, drop CYC_O and STB_O, pulse timeout_o for one cycle, and go to IDLE. rd_data_o is left unchanged and rd_valid_o stays 0.
  - ACK_I and the timeout condition on the same edge: ACK wins and the cycle completes normally.
- Latency:
  - Request accepted at edge N into an empty queue, FSM in IDLE: CYC_O/STB_O are high after edge N+1.
  - Zero-wait responder (ACK on the first STB cycle): CYC_O/STB_O are high for exactly one cycle.
  - Back-to-back queued requests: CYC_O is low for at least one cycle between bus cycles.
- Bus hold rules:
  - ACK_I is ignored while STB_O=0.
  - ADR_O, DAT_O, SEL_O and WE_O are stable for the whole cycle and hold their last values afterwards.
- Simultaneous events:
  - A push and a pop on the same edge when full: the pop frees a slot, but req_ready_o was 0, so no push occurs that edge.
  - A push and a pop on the same edge when neither full nor empty: count is unchanged.
- busy_o: combinational, = !empty | (state==ACTIVE).
- Reset mid-cycle: CYC_O/STB_O drop asynchronously and queued requests are discarded.

Decomposition:
- Package team_06_wb_pkg:
  - typedef struct wb_req_t {we, addr, data, sel}
  - enum wb_mgr_state_t {IDLE, ACTIVE}
  - default parameter constants
- Sub-module team_06_wb_req_fifo:
  - parameterised synchronous FIFO of wb_req_t
  - push, pop, full, empty, async active-low reset
- The FSM and watchdog live in team_06_wb_manager.

Test Plan:
1. Single write: write addr=0x10, data=0xDEADBEEF, sel=0xF; responder ACKs on the first STB cycle. Required: CYC/STB high for 1 cycle; ADR_O=0x10, DAT_O=0xDEADBEEF, WE_O=1; rd_valid_o never pulses; busy_o returns to 0.
2. Read with waits: read addr=0x20; responder ACKs after 3 wait cycles with DAT_I=0x12345678. Required: STB high for 4 cycles; rd_data_o=0x12345678 with a one-cycle rd_valid_o after the ACK edge; WE_O=0.
3. Queue full: 3 consecutive writes to a stalled responder, QDEPTH=2. Required: the first starts a bus cycle and 2 are queued; req_ready_o=0 afterwards; a 4th write is dropped. After ACKs, exactly 3 bus cycles occur, in order, with at least one idle CYC cycle between them.
4. Timeout: read with no ACK, TIMEOUT=8. Required: STB high for exactly 8 cycles, then drops; timeout_o pulses once; rd_valid_o stays 0; rd_data_o is unchanged. A following write proceeds normally.
5. Read/write collision: req_read_i and req_write_i high together on addr 0x30. Required: exactly one bus cycle occurs, with WE_O=1.
6. Reset mid-cycle: assert nrst=0 while STB is high with 1 request queued. Required: CYC/STB go to 0 without waiting for a clock edge; after release, busy_o=0, req_ready_o=1, and no bus cycle starts.
